// File: rtl/thrive_pkg.sv
// Shared defaults and index-width helpers for the register write arbiter.
package thrive_pkg;

  localparam int NREQ_D  = 4;
  localparam int DEPTH_D = 16;
  localparam int DW_D    = 32;

  // Number of bits needed to index n items (never less than one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AW_D = idx_w(DEPTH_D);
  localparam int PW_D = idx_w(NREQ_D);

endpackage

// File: rtl/dffr.sv
// Enabled register with asynchronous active-low reset to a fixed value.
module dffr #(
  parameter int           W = 1,
  parameter logic [W-1:0] R = '0
) (
  input  logic         clk,
  input  logic         rn,
  input  logic         g,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // capture d when enabled, otherwise keep the stored value
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      q <= R;
    end else if (g) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Round-robin one-hot pick: first high req bit at or after ptr, wrapping.
module rr_pick
  import thrive_pkg::*;
#(
  parameter int NREQ = NREQ_D,
  parameter int PW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  localparam int            SW     = PW + 1;
  localparam logic [SW-1:0] NREQ_W = SW'(NREQ);

  logic [SW-1:0] sum_s;
  logic [PW-1:0] idx_s;
  logic          found_s;

  // walk the requesters in priority order from ptr; only the first hit is granted
  always_comb begin
    gnt     = '0;
    sum_s   = '0;
    idx_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sum_s = {1'b0, ptr} + SW'(i);
      if (sum_s >= NREQ_W) begin
        idx_s = PW'(sum_s - NREQ_W);
      end else begin
        idx_s = sum_s[PW-1:0];
      end
      gnt[idx_s] = req[idx_s] & ~found_s;
      found_s    = found_s | req[idx_s];
    end
  end

endmodule

// File: rtl/reg_wr_arb.sv
// Register file written by NREQ requesters through a round-robin arbiter,
// with a combinational read port.
module reg_wr_arb
  import thrive_pkg::*;
#(
  parameter int            NREQ  = NREQ_D,
  parameter int            DEPTH = DEPTH_D,
  parameter int            DW    = DW_D,
  parameter logic [DW-1:0] R     = '0
) (
  input  logic                            clk,
  input  logic                            rn,
  input  logic                            hold,
  input  logic [NREQ-1:0]                 req,
  input  logic [NREQ*idx_w(DEPTH)-1:0]    wr_addr,
  input  logic [NREQ*DW-1:0]              wr_data,
  output logic [NREQ-1:0]                 gnt,
  input  logic [idx_w(DEPTH)-1:0]         rd_addr,
  output logic [DW-1:0]                   rd_data,
  output logic                            busy
);

  localparam int            AW       = idx_w(DEPTH);
  localparam int            PW       = idx_w(NREQ);
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

  logic            run_r;
  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   ptr_nxt_s;
  logic [PW-1:0]   gidx_s;
  logic [NREQ-1:0] req_elig_s;
  logic [NREQ-1:0] pick_s;
  logic            any_gnt_s;
  logic [AW-1:0]   sel_addr_s;
  logic [DW-1:0]   sel_data_s;
  logic [DEPTH-1:0] we_s;
  logic [DW-1:0]   mem_s [DEPTH];

  // arbitration opens only at the first clock edge after reset release
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // hold, or a not-yet-running arbiter, masks every request
  assign req_elig_s = (run_r && !hold) ? req : '0;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req (req_elig_s),
    .ptr (ptr_r),
    .gnt (pick_s)
  );

  assign any_gnt_s = |pick_s;
  assign gnt       = pick_s;
  assign busy      = run_r & (|req) & ~any_gnt_s;

  // one-hot grant steers the winner's index, address and data
  always_comb begin
    gidx_s     = '0;
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      gidx_s     = gidx_s     | (PW'(i) & {PW{pick_s[i]}});
      sel_addr_s = sel_addr_s | (wr_addr[i*AW +: AW] & {AW{pick_s[i]}});
      sel_data_s = sel_data_s | (wr_data[i*DW +: DW] & {DW{pick_s[i]}});
    end
  end

  // pointer moves just past the winner, wrapping after the last requester
  always_comb begin
    if (gidx_s == PTR_LAST) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = gidx_s + PW'(1);
    end
  end

  // pointer advances only in cycles that carry a grant
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      ptr_r <= '0;
    end else if (any_gnt_s) begin
      ptr_r <= ptr_nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // decode the granted address into a single entry write-enable
  always_comb begin
    we_s = '0;
    for (int e = 0; e < DEPTH; e++) begin
      we_s[e] = any_gnt_s & (sel_addr_s == AW'(e));
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    dffr #(
      .W (DW),
      .R (R)
    ) u_entry (
      .clk (clk),
      .rn  (rn),
      .g   (we_s[e]),
      .d   (sel_data_s),
      .q   (mem_s[e])
    );
  end

  // read returns pre-edge contents; a same-cycle write shows up next cycle
  assign rd_data = mem_s[rd_addr];

endmodule
